// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the memory responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-word address for one burst beat, plus a flag for bursts this
// responder does not serve (WRAP, reserved, or non-native beat size).
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int WORD_AW   = 14,
  parameter int SIZE_LOG2 = 2
) (
  input  logic [WORD_AW-1:0] i_addr,
  input  logic [1:0]         i_burst,
  input  logic [2:0]         i_size,
  output logic [WORD_AW-1:0] o_next_addr,
  output logic               o_err
);

  // INCR wraps naturally at the top of the word space; everything else holds.
  always_comb begin
    o_next_addr = i_addr;
    o_err       = 1'b0;
    if (i_burst == BURST_INCR) begin
      o_next_addr = i_addr + 1'b1;
    end
    if (((i_burst != BURST_FIXED) && (i_burst != BURST_INCR)) ||
        (i_size != 3'(SIZE_LOG2))) begin
      o_err = 1'b1;
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI memory slave with independent write and read FSMs.
//
// Handshake rule: on every channel a transfer happens only on a rising
// clock edge where both valid and ready are high; valid never waits on ready.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 16,
  parameter  int ID_WIDTH   = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output w_state_t              o_dbg_w_state,
  output r_state_t              o_dbg_r_state
);

  localparam int BYTE_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_AW  = ADDR_WIDTH - BYTE_LSB;
  localparam int DEPTH    = 1 << WORD_AW;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  w_state_t              r_w_state, w_w_next;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [WORD_AW-1:0]    r_waddr, w_wnext;
  logic [7:0]            r_awlen, r_wcount;
  logic [2:0]            r_awsize;
  logic [1:0]            r_awburst;
  logic                  r_wlast_err, w_werr;

  r_state_t              r_r_state, w_r_next;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [WORD_AW-1:0]    r_raddr, w_rnext, w_rd_word;
  logic [7:0]            r_arlen, r_rcount;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  w_rerr;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wfinal, w_rfinal;
  logic w_unused_addr_lsbs;

  assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_w_hs   = s_axi_wvalid  & s_axi_wready;
  assign w_b_hs   = s_axi_bvalid  & s_axi_bready;
  assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
  assign w_r_hs   = s_axi_rvalid  & s_axi_rready;
  assign w_wfinal = (r_wcount == r_awlen);
  assign w_rfinal = (r_rcount == r_arlen);
  assign w_unused_addr_lsbs = ^{s_axi_awaddr[BYTE_LSB-1:0], s_axi_araddr[BYTE_LSB-1:0]};

  assign o_dbg_w_state = r_w_state;
  assign o_dbg_r_state = r_r_state;

  axi_burst_addr_gen #(.WORD_AW(WORD_AW), .SIZE_LOG2(BYTE_LSB)) u_waddr_gen (
    .i_addr(r_waddr), .i_burst(r_awburst), .i_size(r_awsize),
    .o_next_addr(w_wnext), .o_err(w_werr)
  );

  axi_burst_addr_gen #(.WORD_AW(WORD_AW), .SIZE_LOG2(BYTE_LSB)) u_raddr_gen (
    .i_addr(r_raddr), .i_burst(r_arburst), .i_size(r_arsize),
    .o_next_addr(w_rnext), .o_err(w_rerr)
  );

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_w_state <= W_IDLE;
    else          r_w_state <= w_w_next;
  end

  // Write FSM next state: the beat counter, not wlast, ends the burst.
  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_aw_hs)             w_w_next = W_DATA;
      W_DATA:  if (w_w_hs && w_wfinal)  w_w_next = W_RESP;
      W_RESP:  if (w_b_hs)              w_w_next = W_IDLE;
      default:                          w_w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    case (r_w_state)
      W_IDLE: s_axi_awready = 1'b1;
      W_DATA: s_axi_wready  = 1'b1;
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (w_werr || r_wlast_err) s_axi_bresp = RESP_SLVERR;
      end
      default: ;
    endcase
  end

  assign s_axi_bid = r_awid;

  // Write burst context: latched on AW, stepped on each W beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_awid      <= '0;
      r_waddr     <= '0;
      r_awlen     <= '0;
      r_awsize    <= '0;
      r_awburst   <= '0;
      r_wcount    <= '0;
      r_wlast_err <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid      <= s_axi_awid;
      r_waddr     <= s_axi_awaddr[ADDR_WIDTH-1:BYTE_LSB];
      r_awlen     <= s_axi_awlen;
      r_awsize    <= s_axi_awsize;
      r_awburst   <= s_axi_awburst;
      r_wcount    <= '0;
      r_wlast_err <= 1'b0;
    end else if (w_w_hs) begin
      r_waddr  <= w_wnext;
      r_wcount <= r_wcount + 8'd1;
      if (s_axi_wlast != w_wfinal) r_wlast_err <= 1'b1;
    end
  end

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_w_hs && !w_werr) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_waddr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_r_state <= R_IDLE;
    else          r_r_state <= w_r_next;
  end

  // Read FSM next state.
  always_comb begin
    w_r_next = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_ar_hs)            w_r_next = R_DATA;
      R_DATA:  if (w_r_hs && w_rfinal) w_r_next = R_IDLE;
      default:                         w_r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs; error bursts return zero data.
  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = RESP_OKAY;
    s_axi_rdata   = '0;
    case (r_r_state)
      R_IDLE: s_axi_arready = 1'b1;
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = w_rfinal;
        if (w_rerr) s_axi_rresp = RESP_SLVERR;
        else        s_axi_rdata = r_rdata;
      end
      default: ;
    endcase
  end

  assign s_axi_rid = r_arid;

  // Word fetched for the next beat: AR address when idle, else the stepped one.
  assign w_rd_word = (r_r_state == R_IDLE) ? s_axi_araddr[ADDR_WIDTH-1:BYTE_LSB] : w_rnext;

  // Read burst context and the registered beat data (pre-write on collisions).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_arid    <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcount  <= '0;
      r_rdata   <= '0;
    end else if (w_ar_hs) begin
      r_arid    <= s_axi_arid;
      r_raddr   <= w_rd_word;
      r_arlen   <= s_axi_arlen;
      r_arsize  <= s_axi_arsize;
      r_arburst <= s_axi_arburst;
      r_rcount  <= '0;
      r_rdata   <= r_mem[w_rd_word];
    end else if (w_r_hs && !w_rfinal) begin
      r_raddr  <= w_rd_word;
      r_rcount <= r_rcount + 8'd1;
      r_rdata  <= r_mem[w_rd_word];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized scoreboard bench for axi_mem_responder with a word-array memory model.
module tb_axi_mem_responder;
  import axi_pkg::*;

  localparam int WORDS = 16384;

  logic        clock, reset_n;
  logic [7:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  w_state_t    dbg_w_state;
  r_state_t    dbg_r_state;

  typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      exp_b_q[$];
  r_exp_t      exp_r_q[$];
  logic [31:0] ref_mem [WORDS];
  int          checks = 0, errors = 0;
  int          b_seen = 0, r_seen = 0;
  bit          rand_ready = 1;
  logic        force_rready = 1, force_bready = 1;
  r_exp_t      mon_r, held_r;
  b_exp_t      mon_b;
  bit          hold_pending = 0;

  axi_mem_responder dut (
    .clock(clock), .reset_n(reset_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .o_dbg_w_state(dbg_w_state), .o_dbg_r_state(dbg_r_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_w_state", dbg_w_state, W_IDLE);
    check("rst_r_state", dbg_r_state, R_IDLE);
  endtask

  // ---------------- ready generator ----------------
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) begin
        rready = ($urandom_range(0, 3) != 0);
        bready = ($urandom_range(0, 3) != 0);
      end else begin
        rready = force_rready;
        bready = force_bready;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_pending = 0;
    end else begin
      if (hold_pending && rvalid)
        check("r_hold_stable", {rid, rdata, rresp, rlast}, {held_r.id, held_r.data, held_r.resp, held_r.last});
      hold_pending = rvalid && !rready;
      held_r = '{id: rid, data: rdata, resp: rresp, last: rlast};
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual rdata=%0h expected no beat t=%0t", rdata, $time);
        end else begin
          mon_r = exp_r_q.pop_front();
          check("r_data", rdata, mon_r.data);
          check("r_id", rid, mon_r.id);
          check("r_resp", rresp, mon_r.resp);
          check("r_last", rlast, mon_r.last);
        end
        r_seen++;
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual bresp=%0h expected no response t=%0t", bresp, $time);
        end else begin
          mon_b = exp_b_q.pop_front();
          check("b_id", bid, mon_b.id);
          check("b_resp", bresp, mon_b.resp);
        end
        b_seen++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_b(input int target);
    int n = 0;
    while (b_seen < target && n < 300) begin @(negedge clock); n++; end
    if (b_seen < target) begin
      checks++; errors++;
      $display("FAIL b_timeout actual seen=%0d expected=%0d", b_seen, target);
    end
    step();
  endtask

  task automatic wait_r(input int target);
    int n = 0;
    while (r_seen < target && n < 1000) begin @(negedge clock); n++; end
    if (r_seen < target) begin
      checks++; errors++;
      $display("FAIL r_timeout actual seen=%0d expected=%0d", r_seen, target);
    end
    step();
  endtask

  // Issues a full write burst; abort_after >= 0 pulses reset before that beat.
  task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] d0, input logic [3:0] s0,
                          input bit rnd_data, input bit rnd_strb, input bit bad_last,
                          input int abort_after);
    logic [31:0] d[256];
    logic [3:0]  s[256];
    logic        l[256];
    bit          cfg_err, last_err;
    int          word, target, n;
    cfg_err  = (burst != BURST_FIXED && burst != BURST_INCR) || (size != 3'd2);
    last_err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = rnd_data ? $urandom : d0;
      s[i] = rnd_strb ? 4'($urandom_range(0, 15)) : s0;
      l[i] = (i == int'(len));
      if (bad_last && $urandom_range(0, 3) == 0) l[i] = ~l[i];
    end
    if (bad_last) begin
      for (int i = 0; i <= int'(len); i++) if (l[i] != (i == int'(len))) last_err = 1;
      if (!last_err) begin l[len] = 1'b0; last_err = 1; end
    end
    target = b_seen + 1;
    if (abort_after < 0)
      exp_b_q.push_back('{id: id, resp: (cfg_err || last_err) ? RESP_SLVERR : RESP_OKAY});
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!awready && n < 100);
    if (!awready) begin
      checks++; errors++;
      $display("FAIL aw_timeout actual awready=0 expected 1");
    end
    step();
    awvalid = 1'b0;
    word = int'(addr[15:2]);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_after) begin
        #2 reset_n = 1'b0;
        wvalid = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        step();
        repeat (10) step();
        @(negedge clock);
        check("abort_awready", awready, 1);
        check("abort_no_bvalid", bvalid, 0);
        step();
        return;
      end
      wdata = d[i]; wstrb = s[i]; wlast = l[i]; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!wready && n < 100);
      if (!wready) begin
        checks++; errors++;
        $display("FAIL w_timeout actual wready=0 expected 1");
        wvalid = 1'b0;
        return;
      end
      step();
      wvalid = 1'b0;
      if (!cfg_err)
        for (int b = 0; b < 4; b++) if (s[i][b]) ref_mem[word][8*b +: 8] = d[i][8*b +: 8];
      if (burst == BURST_INCR) word = (word + 1) % WORDS;
      repeat ($urandom_range(0, 2)) step();
    end
    wait_b(target);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit cfg_err;
    int word, target, n;
    cfg_err = (burst != BURST_FIXED && burst != BURST_INCR) || (size != 3'd2);
    word = int'(addr[15:2]);
    for (int i = 0; i <= int'(len); i++) begin
      exp_r_q.push_back('{id: id, data: cfg_err ? 32'h0 : ref_mem[word],
                          resp: cfg_err ? RESP_SLVERR : RESP_OKAY, last: (i == int'(len))});
      if (burst == BURST_INCR) word = (word + 1) % WORDS;
    end
    target = r_seen + int'(len) + 1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready && n < 100);
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_timeout actual arready=0 expected 1");
    end
    step();
    arvalid = 1'b0;
    wait_r(target);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st, bt, rt, w;
    logic [7:0] ln;
    logic [1:0] bu;
    logic [2:0] sz;
    reset_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wdata = 0; wstrb = 0; wlast = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    #12 check_reset_outputs();
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    step();

    // Known contents for the low and top word windows.
    do_write(8'h01, 16'h0000, 8'd31, 3'd2, BURST_INCR, 0, 4'hF, 1, 0, 0, -1);
    do_write(8'h02, 16'hFFC0, 8'd15, 3'd2, BURST_INCR, 0, 4'hF, 1, 0, 0, -1);

    // Single write then read back.
    do_write(8'h5A, 16'h0010, 8'd0, 3'd2, BURST_INCR, 32'hDEADBEEF, 4'hF, 0, 0, 0, -1);
    do_read(8'h11, 16'h0010, 8'd0, 3'd2, BURST_INCR);
    // INCR read wrapping past the top word.
    do_read(8'h12, 16'hFFFC, 8'd1, 3'd2, BURST_INCR);
    // Strobed write over a known word.
    do_write(8'h21, 16'h0020, 8'd0, 3'd2, BURST_INCR, 32'hAABBCCDD, 4'hF, 0, 0, 0, -1);
    do_write(8'h22, 16'h0020, 8'd0, 3'd2, BURST_INCR, 32'h11223344, 4'b0101, 0, 0, 0, -1);
    do_read(8'h23, 16'h0020, 8'd0, 3'd2, BURST_INCR);

    // Backpressure on R mid-burst and on B.
    rand_ready = 0; force_rready = 1; force_bready = 1;
    st = r_seen;
    fork
      do_read(8'h31, 16'h0000, 8'd5, 3'd2, BURST_INCR);
      begin
        int n = 0;
        while (r_seen < st + 2 && n < 200) begin @(negedge clock); n++; end
        force_rready = 0;
        repeat (4) step();
        force_rready = 1;
      end
    join
    force_bready = 0;
    fork
      do_write(8'h32, 16'h0008, 8'd0, 3'd2, BURST_INCR, 0, 4'hF, 1, 0, 0, -1);
      begin
        int n = 0;
        while (!bvalid && n < 200) begin @(negedge clock); n++; end
        repeat (5) begin
          @(negedge clock);
          check("b_held", bvalid, 1);
        end
        force_bready = 1;
      end
    join
    rand_ready = 1;

    // Error bursts: WRAP write leaves memory alone, narrow read returns zero.
    do_write(8'h41, 16'h0040, 8'd3, 3'd2, BURST_WRAP, 0, 4'hF, 1, 0, 0, -1);
    do_read(8'h42, 16'h0040, 8'd3, 3'd2, BURST_INCR);
    do_read(8'h43, 16'h0000, 8'd2, 3'd1, BURST_INCR);
    // Misplaced wlast still writes but reports SLVERR.
    do_write(8'h44, 16'h0030, 8'd3, 3'd2, BURST_INCR, 0, 4'hF, 1, 0, 1, -1);
    do_read(8'h45, 16'h0030, 8'd3, 3'd2, BURST_INCR);

    // Read and write of the same word on the same edge returns old data.
    bt = b_seen + 1; rt = r_seen + 1;
    exp_b_q.push_back('{id: 8'h51, resp: RESP_OKAY});
    exp_r_q.push_back('{id: 8'h52, data: ref_mem[5], resp: RESP_OKAY, last: 1'b1});
    awid = 8'h51; awaddr = 16'h0014; awlen = 0; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1;
    @(negedge clock);
    check("rw_aw_ready", awready, 1);
    step();
    awvalid = 0;
    wdata = 32'hC0FFEE11; wstrb = 4'hF; wlast = 1; wvalid = 1;
    arid = 8'h52; araddr = 16'h0014; arlen = 0; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1;
    @(negedge clock);
    check("rw_same_edge_ready", {wready, arready}, 2'b11);
    step();
    wvalid = 0; arvalid = 0;
    ref_mem[5] = 32'hC0FFEE11;
    wait_b(bt);
    wait_r(rt);
    do_read(8'h53, 16'h0014, 8'd0, 3'd2, BURST_INCR);

    // Reset in the middle of a long write, then normal traffic.
    do_write(8'h61, 16'h0000, 8'd7, 3'd2, BURST_INCR, 0, 4'hF, 1, 0, 0, 3);
    do_write(8'h62, 16'h0004, 8'd1, 3'd2, BURST_INCR, 0, 4'hF, 1, 0, 0, -1);
    do_read(8'h63, 16'h0000, 8'd7, 3'd2, BURST_INCR);

    // Randomized traffic inside the known windows.
    for (int k = 0; k < 40; k++) begin
      w  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 24) : WORDS - 8 + $urandom_range(0, 7);
      ln = 8'($urandom_range(0, 7));
      st = $urandom_range(0, 9);
      bu = (st < 5) ? BURST_INCR : (st < 8) ? BURST_FIXED : (st == 8) ? BURST_WRAP : 2'b11;
      sz = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) != 0)
        do_write(8'($urandom), 16'(w * 4), ln, sz, bu, 0, 4'hF, 1, 1,
                 ($urandom_range(0, 4) == 0), -1);
      else
        do_read(8'($urandom), 16'(w * 4), ln, sz, bu);
    end

    repeat (10) step();
    check("exp_b_q_empty", exp_b_q.size(), 0);
    check("exp_r_q_empty", exp_r_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
